// File: rtl/pattern_scan_if.sv
// Bus between a host/bit source and the pattern scan controller.
// The master drives config, scan control and serial data; the slave
// returns the match flag, the match count and the status pulses.
interface pattern_scan_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             cfg_we;
    logic [PAT_W-1:0] cfg_pattern;
    logic [3:0]       cfg_len;
    logic             cfg_overlap;
    logic [CNT_W-1:0] target;
    logic             start;
    logic             abort;
    logic             x;
    logic             x_valid;
    logic             found;
    logic [CNT_W-1:0] match_count;
    logic             busy;
    logic             done;
    logic             cfg_err;

    modport master (
        output cfg_we, cfg_pattern, cfg_len, cfg_overlap, target,
        output start, abort, x, x_valid,
        input  found, match_count, busy, done, cfg_err
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, target,
        input  start, abort, x, x_valid,
        output found, match_count, busy, done, cfg_err
    );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Programmable serial Mealy pattern detector with a scan controller.
// The pattern, its length and the overlap mode are written in IDLE. A start
// arms a scan that counts matches until the target is reached. The found
// flag is combinational, so it is high in the same cycle as the matching bit.
module pattern_scan_ctrl #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    pattern_scan_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0]       PAT_W_L = 4'(PAT_W);
    localparam logic [PAT_W-1:0] PAT_RST = PAT_W'(8'b0000_1010);

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic [3:0]       len_q, len_d;
    logic             overlap_q, overlap_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PAT_W-2:0] hist_q, hist_d;
    logic [3:0]       fill_q, fill_d;
    logic             cfg_err_q, cfg_err_d;

    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] len_mask;
    logic [3:0]       fill_next;
    logic             match;
    logic [3:0]       start_len;
    logic             start_ok;
    logic [CNT_W-1:0] count_inc;
    logic             found_c;

    // Match datapath: the newest bit sits at window[0], so the bit received
    // len-1 bits ago lines up with pattern[len-1].
    always_comb begin
        window    = {hist_q, bus.x};
        len_mask  = ~({PAT_W{1'b1}} << len_q);
        fill_next = (fill_q >= PAT_W_L) ? PAT_W_L : fill_q + 4'd1;
        match     = (fill_next >= len_q) && (((window ^ pattern_q) & len_mask) == '0);
        count_inc = count_q + CNT_W'(1);
        // A config write in the same cycle as start is validated first.
        start_len = bus.cfg_we ? bus.cfg_len : len_q;
        start_ok  = (start_len != 4'd0) && (start_len <= PAT_W_L) && (bus.target != '0);
    end

    // Next-state and output logic for the IDLE/SCAN/DONE controller.
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        target_d  = target_q;
        count_d   = count_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        cfg_err_d = 1'b0;
        found_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cfg_we) begin
                    pattern_d = bus.cfg_pattern;
                    len_d     = bus.cfg_len;
                    overlap_d = bus.cfg_overlap;
                end
                if (bus.start) begin
                    if (start_ok) begin
                        count_d  = '0;
                        hist_d   = '0;
                        fill_d   = 4'd0;
                        target_d = bus.target;
                        state_d  = ST_SCAN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                if (bus.cfg_we) begin
                    cfg_err_d = 1'b1;
                end
                // Abort beats a simultaneous match: nothing is counted.
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (bus.x_valid) begin
                    if (match) begin
                        found_c = 1'b1;
                        count_d = count_inc;
                        if (overlap_q) begin
                            hist_d = window[PAT_W-2:0];
                            fill_d = fill_next;
                        end else begin
                            hist_d = '0;
                            fill_d = 4'd0;
                        end
                        if (count_inc == target_q) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        hist_d = window[PAT_W-2:0];
                        fill_d = fill_next;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and configuration registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            pattern_q <= PAT_RST;
            len_q     <= 4'd4;
            overlap_q <= 1'b0;
            target_q  <= '0;
            count_q   <= '0;
            hist_q    <= '0;
            fill_q    <= 4'd0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            target_q  <= target_d;
            count_q   <= count_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign bus.found       = found_c;
    assign bus.match_count = count_q;
    assign bus.busy        = (state_q == ST_SCAN);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Table-driven bench for pattern_scan_ctrl. Each record holds the inputs
// for one clock cycle and the outputs expected during that cycle (before
// the edge that consumes the inputs).
module tb_pattern_scan_ctrl;
    logic clk;
    logic reset;

    pattern_scan_if #(.PAT_W(4), .CNT_W(8)) bus ();

    pattern_scan_ctrl #(.PAT_W(4), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       we;
        logic [3:0] pat;
        logic [3:0] len;
        logic       ov;
        logic [7:0] tgt;
        logic       st;
        logic       ab;
        logic       xv;
        logic       x;
        logic       ef;
        logic [7:0] ec;
        logic       eb;
        logic       ed;
        logic       ee;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t tbl[$];

    function automatic vec_t mkv(logic rst_n, logic we, logic [3:0] pat, logic [3:0] len,
                                 logic ov, logic [7:0] tgt, logic st, logic ab, logic xv,
                                 logic x, logic ef, logic [7:0] ec, logic eb, logic ed,
                                 logic ee);
        vec_t v;
        v.rst_n = rst_n; v.we = we; v.pat = pat; v.len = len; v.ov = ov; v.tgt = tgt;
        v.st = st; v.ab = ab; v.xv = xv; v.x = x;
        v.ef = ef; v.ec = ec; v.eb = eb; v.ed = ed; v.ee = ee;
        return v;
    endfunction

    // Control cycle: config write and/or start, no serial data.
    function automatic vec_t ctl(logic we, logic [3:0] pat, logic [3:0] len, logic ov,
                                 logic [7:0] tgt, logic st, logic [7:0] ec, logic eb,
                                 logic ed, logic ee);
        return mkv(1'b1, we, pat, len, ov, tgt, st, 1'b0, 1'b0, 1'b0, 1'b0, ec, eb, ed, ee);
    endfunction

    // Data cycle: serial bit (optionally qualified) and abort.
    function automatic vec_t bv(logic xv, logic x, logic ab, logic ef, logic [7:0] ec,
                                logic eb, logic ed, logic ee);
        return mkv(1'b1, 1'b0, 4'b0, 4'd0, 1'b0, 8'd0, 1'b0, ab, xv, x, ef, ec, eb, ed, ee);
    endfunction

    task automatic chk(input int idx, input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL vec %0d %s: got %0h expected %0h", idx, name, act, exp);
        end
    endtask

    task automatic run(input int idx, input vec_t v);
        @(posedge clk);
        #1;
        reset           = v.rst_n;
        bus.cfg_we      = v.we;
        bus.cfg_pattern = v.pat;
        bus.cfg_len     = v.len;
        bus.cfg_overlap = v.ov;
        bus.target      = v.tgt;
        bus.start       = v.st;
        bus.abort       = v.ab;
        bus.x_valid     = v.xv;
        bus.x           = v.x;
        @(negedge clk);
        chk(idx, "found",       {7'd0, bus.found},   {7'd0, v.ef});
        chk(idx, "match_count", bus.match_count,     v.ec);
        chk(idx, "busy",        {7'd0, bus.busy},    {7'd0, v.eb});
        chk(idx, "done",        {7'd0, bus.done},    {7'd0, v.ed});
        chk(idx, "cfg_err",     {7'd0, bus.cfg_err}, {7'd0, v.ee});
        $display("vec %0d rst=%0b st=%0b xv=%0b x=%0b ab=%0b -> found=%0b cnt=%0d busy=%0b done=%0b err=%0b",
                 idx, v.rst_n, v.st, v.xv, v.x, v.ab, bus.found, bus.match_count,
                 bus.busy, bus.done, bus.cfg_err);
    endtask

    initial begin
        reset = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_pattern = 4'b0; bus.cfg_len = 4'd0; bus.cfg_overlap = 1'b0;
        bus.target = 8'd0; bus.start = 1'b0; bus.abort = 1'b0;
        bus.x_valid = 1'b0; bus.x = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state.
        tbl.push_back(mkv(1'b0, 1'b0, 4'b0, 4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                          1'b0, 8'd0, 1'b0, 1'b0, 1'b0));
        // Defaults 1010/len4/no overlap, target 1.
        tbl.push_back(ctl(1'b0, 4'b0, 4'd0, 1'b0, 8'd1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(bv(1, 1, 0, 0, 8'd0, 1, 0, 0));
        tbl.push_back(bv(1, 0, 0, 0, 8'd0, 1, 0, 0));
        tbl.push_back(bv(1, 1, 0, 0, 8'd0, 1, 0, 0));
        tbl.push_back(bv(1, 0, 0, 1, 8'd0, 1, 0, 0));
        tbl.push_back(bv(0, 0, 0, 0, 8'd1, 0, 1, 0));
        tbl.push_back(bv(0, 0, 0, 0, 8'd1, 0, 0, 0));
        // Overlap on, target 3, config written with start.
        tbl.push_back(ctl(1'b1, 4'b1010, 4'd4, 1'b1, 8'd3, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(bv(1, 1, 0, 0, 8'd0, 1, 0, 0));
        tbl.push_back(bv(1, 0, 0, 0, 8'd0, 1, 0, 0));
        tbl.push_back(bv(1, 1, 0, 0, 8'd0, 1, 0, 0));
        tbl.push_back(bv(1, 0, 0, 1, 8'd0, 1, 0, 0));
        tbl.push_back(bv(1, 1, 0, 0, 8'd1, 1, 0, 0));
        tbl.push_back(bv(1, 0, 0, 1, 8'd1, 1, 0, 0));
        tbl.push_back(bv(1, 1, 0, 0, 8'd2, 1, 0, 0));
        tbl.push_back(bv(1, 0, 0, 1, 8'd2, 1, 0, 0));
        tbl.push_back(bv(0, 0, 0, 0, 8'd3, 0, 1, 0));
        tbl.push_back(bv(0, 0, 0, 0, 8'd3, 0, 0, 0));
        // Overlap off, target 2: no hit on bit 6.
        tbl.push_back(ctl(1'b1, 4'b1010, 4'd4, 1'b0, 8'd2, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0));
        tbl.push_back(bv(1, 1, 0, 0, 8'd0, 1, 0, 0));
        tbl.push_back(bv(1, 0, 0, 0, 8'd0, 1, 0, 0));
        tbl.push_back(bv(1, 1, 0, 0, 8'd0, 1, 0, 0));
        tbl.push_back(bv(1, 0, 0, 1, 8'd0, 1, 0, 0));
        tbl.push_back(bv(1, 1, 0, 0, 8'd1, 1, 0, 0));
        tbl.push_back(bv(1, 0, 0, 0, 8'd1, 1, 0, 0));
        tbl.push_back(bv(1, 1, 0, 0, 8'd1, 1, 0, 0));
        tbl.push_back(bv(1, 0, 0, 1, 8'd1, 1, 0, 0));
        tbl.push_back(bv(0, 0, 0, 0, 8'd2, 0, 1, 0));
        // Target 5, x_valid gap, then abort.
        tbl.push_back(ctl(1'b0, 4'b0, 4'd0, 1'b0, 8'd5, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0));
        tbl.push_back(bv(1, 1, 0, 0, 8'd0, 1, 0, 0));
        tbl.push_back(bv(1, 0, 0, 0, 8'd0, 1, 0, 0));
        tbl.push_back(bv(0, 1, 0, 0, 8'd0, 1, 0, 0));
        tbl.push_back(bv(0, 1, 0, 0, 8'd0, 1, 0, 0));
        tbl.push_back(bv(0, 0, 0, 0, 8'd0, 1, 0, 0));
        tbl.push_back(bv(1, 1, 0, 0, 8'd0, 1, 0, 0));
        tbl.push_back(bv(1, 0, 0, 1, 8'd0, 1, 0, 0));
        tbl.push_back(bv(0, 0, 1, 0, 8'd1, 1, 0, 0));
        tbl.push_back(bv(0, 0, 0, 0, 8'd1, 0, 0, 0));
        tbl.push_back(bv(0, 0, 0, 0, 8'd1, 0, 0, 0));
        // Abort in the same cycle as a would-be match.
        tbl.push_back(ctl(1'b0, 4'b0, 4'd0, 1'b0, 8'd5, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(bv(1, 1, 0, 0, 8'd0, 1, 0, 0));
        tbl.push_back(bv(1, 0, 0, 0, 8'd0, 1, 0, 0));
        tbl.push_back(bv(1, 1, 0, 0, 8'd0, 1, 0, 0));
        tbl.push_back(bv(1, 0, 1, 0, 8'd0, 1, 0, 0));
        tbl.push_back(bv(0, 0, 0, 0, 8'd0, 0, 0, 0));
        // Config write during SCAN is rejected and leaves pattern 1010.
        tbl.push_back(ctl(1'b0, 4'b0, 4'd0, 1'b0, 8'd1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(ctl(1'b1, 4'b0011, 4'd2, 1'b1, 8'd1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0));
        tbl.push_back(bv(0, 0, 0, 0, 8'd0, 1, 0, 1));
        tbl.push_back(bv(1, 1, 0, 0, 8'd0, 1, 0, 0));
        tbl.push_back(bv(1, 0, 0, 0, 8'd0, 1, 0, 0));
        tbl.push_back(bv(1, 1, 0, 0, 8'd0, 1, 0, 0));
        tbl.push_back(bv(1, 0, 0, 1, 8'd0, 1, 0, 0));
        tbl.push_back(bv(0, 0, 0, 0, 8'd1, 0, 1, 0));
        // Start with len 0 written in the same cycle.
        tbl.push_back(ctl(1'b1, 4'b1010, 4'd0, 1'b0, 8'd1, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(bv(0, 0, 0, 0, 8'd1, 0, 0, 1));
        tbl.push_back(bv(0, 0, 0, 0, 8'd1, 0, 0, 0));
        // Start with target 0.
        tbl.push_back(ctl(1'b1, 4'b1010, 4'd4, 1'b0, 8'd0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(bv(0, 0, 0, 0, 8'd1, 0, 0, 1));
        tbl.push_back(bv(0, 0, 0, 0, 8'd1, 0, 0, 0));
        // Start with len above PAT_W.
        tbl.push_back(ctl(1'b1, 4'b1010, 4'd5, 1'b0, 8'd1, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(bv(0, 0, 0, 0, 8'd1, 0, 0, 1));
        tbl.push_back(bv(0, 0, 0, 0, 8'd1, 0, 0, 0));
        // Pattern 11 (len 2, overlap) gives two matches, then reset mid-scan.
        tbl.push_back(ctl(1'b1, 4'b0011, 4'd2, 1'b1, 8'd5, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(bv(1, 1, 0, 0, 8'd0, 1, 0, 0));
        tbl.push_back(bv(1, 1, 0, 1, 8'd0, 1, 0, 0));
        tbl.push_back(bv(1, 1, 0, 1, 8'd1, 1, 0, 0));
        tbl.push_back(mkv(1'b0, 1'b0, 4'b0, 4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                          1'b0, 8'd2, 1'b1, 1'b0, 1'b0));
        // After reset the pattern is 1010 again.
        tbl.push_back(ctl(1'b0, 4'b0, 4'd0, 1'b0, 8'd1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(bv(1, 1, 0, 0, 8'd0, 1, 0, 0));
        tbl.push_back(bv(1, 0, 0, 0, 8'd0, 1, 0, 0));
        tbl.push_back(bv(1, 1, 0, 0, 8'd0, 1, 0, 0));
        tbl.push_back(bv(1, 0, 0, 1, 8'd0, 1, 0, 0));
        tbl.push_back(bv(0, 0, 0, 0, 8'd1, 0, 1, 0));
        tbl.push_back(bv(0, 0, 0, 0, 8'd1, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            run(i, tbl[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
